// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
// Optional feature macro: CLK_DIV_DUTY_EN (programmable high time).
package clk_div_pkg;

  localparam int unsigned RATIO_WD_DEF = 8;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    BYPASS   = 2'd1,
    DIVIDE   = 2'd2
  } chan_mode_e;

  // ceil(a/2), written as a - floor(a/2) so it cannot overflow
  function automatic logic [31:0] ceil_half(input logic [31:0] a);
    return a - (a >> 1);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One independent divider channel.
// Optional feature macro: CLK_DIV_DUTY_EN adds i_high_time (programmable high time).
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned RATIO_WD = RATIO_WD_DEF
) (
  input  logic                i_ref_clk,
  input  logic                i_rst,
  input  logic                i_clk_en,
  input  logic [RATIO_WD-1:0] i_div_ratio,
`ifdef CLK_DIV_DUTY_EN
  input  logic [RATIO_WD-1:0] i_high_time,
`endif
  output logic                o_div_clk,
  output logic                o_tick,
  output logic                o_bypass
);

  logic [RATIO_WD-1:0] a_q, a_d;
  logic [RATIO_WD-1:0] h_q, h_d;
  logic [RATIO_WD-1:0] cnt_q, cnt_d;
  logic                div_q, div_d;
  logic                tick_q, tick_d;
  logic [RATIO_WD-1:0] h_load;
  chan_mode_e          mode;

  // High time to load alongside the incoming ratio
  always_comb begin
    h_load = RATIO_WD'(ceil_half(32'(i_div_ratio)));
`ifdef CLK_DIV_DUTY_EN
    if ((i_high_time != '0) && (i_high_time < i_div_ratio)) begin
      h_load = i_high_time;
    end
`endif
  end

  // Channel mode from the live enable and the active ratio
  always_comb begin
    if (!i_clk_en) begin
      mode = DISABLED;
    end else if (a_q[RATIO_WD-1:1] == '0) begin
      mode = BYPASS;
    end else begin
      mode = DIVIDE;
    end
  end

  // Next state: cnt_q is the position within the period that the next edge emits
  always_comb begin
    a_d    = a_q;
    h_d    = h_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    tick_d = tick_q;
    unique case (mode)
      DISABLED, BYPASS: begin
        a_d    = i_div_ratio;
        h_d    = h_load;
        cnt_d  = '0;
        div_d  = 1'b0;
        tick_d = 1'b0;
      end
      DIVIDE: begin
        div_d  = (cnt_q < h_q);
        tick_d = (cnt_q == '0);
        if (cnt_q == a_q - RATIO_WD'(1)) begin
          cnt_d = '0;
          a_d   = i_div_ratio;
          h_d   = h_load;
        end else begin
          cnt_d = cnt_q + RATIO_WD'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      a_q    <= '0;
      h_q    <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      h_q    <= h_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  // Outputs: bypass passes the reference clock straight through
  always_comb begin
    o_div_clk = 1'b0;
    o_tick    = 1'b0;
    o_bypass  = 1'b0;
    if (!i_rst) begin
      unique case (mode)
        BYPASS: begin
          o_div_clk = i_ref_clk;
          o_tick    = 1'b1;
          o_bypass  = 1'b1;
        end
        DIVIDE: begin
          o_div_clk = div_q;
          o_tick    = tick_q;
        end
        default: begin
          o_div_clk = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// N_CH independent clock dividers sharing one reference clock.
// Optional feature macro: CLK_DIV_DUTY_EN adds i_high_time (programmable high time).
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned RATIO_WD = RATIO_WD_DEF
) (
  input  logic                     i_ref_clk,
  input  logic                     i_rst,
  input  logic [N_CH-1:0]          i_clk_en,
  input  logic [N_CH*RATIO_WD-1:0] i_div_ratio,
`ifdef CLK_DIV_DUTY_EN
  input  logic [N_CH*RATIO_WD-1:0] i_high_time,
`endif
  output logic [N_CH-1:0]          o_div_clk,
  output logic [N_CH-1:0]          o_tick,
  output logic [N_CH-1:0]          o_bypass
);

  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    clk_div_chan #(
      .RATIO_WD(RATIO_WD)
    ) u_chan (
      .i_ref_clk  (i_ref_clk),
      .i_rst      (i_rst),
      .i_clk_en   (i_clk_en[c]),
      .i_div_ratio(i_div_ratio[c*RATIO_WD +: RATIO_WD]),
`ifdef CLK_DIV_DUTY_EN
      .i_high_time(i_high_time[c*RATIO_WD +: RATIO_WD]),
`endif
      .o_div_clk  (o_div_clk[c]),
      .o_tick     (o_tick[c]),
      .o_bypass   (o_bypass[c])
    );
  end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning the number of independent divider channels.
REQ-002 SHALL have parameter RATIO_WD, default 8, meaning the width of each channel's ratio field.
REQ-003 SHALL have port i_ref_clk, input, 1 bit: the single reference clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port i_clk_en, input, N_CH bits: per-channel enable.
REQ-006 SHALL have port i_div_ratio, input, N_CH*RATIO_WD bits: per-channel requested ratio; channel c occupies bits [c*RATIO_WD +: RATIO_WD].
REQ-007 SHALL have port o_div_clk, output, N_CH bits: the per-channel divided clock.
REQ-008 SHALL have port o_tick, output, N_CH bits: a 1-cycle pulse marking the start of each divided period.
REQ-009 SHALL have port o_bypass, output, N_CH bits: high while the channel's active ratio is 0 or 1.

Function
REQ-010 Channels SHALL be fully independent; no state is shared between them.
REQ-011 Each channel SHALL hold the following registered state:
- active ratio A, RATIO_WD bits;
- high time H;
- period counter cnt, RATIO_WD bits;
- div_clk;
- tick.
REQ-012 When i_clk_en[c] is sampled low, the channel SHALL drive cnt=0, div_clk=0 and tick=0, and SHALL load A from i_div_ratio every cycle.
REQ-013 The default high time SHALL be H = A - (A>>1), i.e. ceil(A/2); the low time is A>>1. This gives 50% duty for even A, and the high phase is one cycle longer for odd A.
REQ-014 Divide mode (A>=2), counting enabled edges k=0,1,2,... from the first edge with i_clk_en[c]=1:
- after edge k, div_clk SHALL be 1 iff (k mod A) < H;
- after edge k, tick SHALL be 1 iff (k mod A)==0.
REQ-015 o_div_clk[c] SHALL equal div_clk in divide mode and SHALL equal 0 while disabled.
REQ-016 The first rising edge of o_div_clk[c] SHALL occur one i_ref_clk cycle after enable is first sampled high.
REQ-017 Ratio updates in divide mode SHALL be glitch-free:
- i_div_ratio is sampled only on the edge where cnt==A-1 (period end);
- the new A applies from the next period;
- mid-period changes of i_div_ratio SHALL NOT alter the current period.
REQ-018 Bypass mode (enabled, A in {0,1}):
- o_div_clk[c] SHALL equal i_ref_clk combinationally;
- o_tick[c] SHALL be held at 1;
- o_bypass[c] SHALL be 1;
- A SHALL be reloaded from i_div_ratio every cycle.
REQ-019 Leaving bypass (a newly loaded A>=2) SHALL start divide mode at k=0 on the following edge.
REQ-020 Counter wrap: cnt SHALL return to 0 after A-1. With RATIO_WD=8 and A=255, cnt SHALL never exceed 254.
REQ-021 Simultaneous enable drop and period end: disable SHALL take priority, and the ratio load SHALL follow REQ-012.

Reset
REQ-022 While i_rst=1 at a clock edge, every channel SHALL clear A, cnt, div_clk and tick to 0.
REQ-023 While i_rst=1, o_div_clk SHALL be 0, o_tick SHALL be 0 and o_bypass SHALL be 0, regardless of i_clk_en.
REQ-024 Reset applied mid-period SHALL abandon the period; the channel restarts at k=0 once reset is released and enable is high.

Configuration
REQ-025 Macro CLK_DIV_DUTY_EN SHALL control programmable duty cycle.
REQ-026 When CLK_DIV_DUTY_EN is defined:
- an input port i_high_time, N_CH*RATIO_WD bits, SHALL be added;
- H SHALL be loaded from i_high_time at the same instants A is loaded;
- a loaded value of 0, or >=A, SHALL be replaced by ceil(A/2).
REQ-027 When CLK_DIV_DUTY_EN is undefined, no i_high_time port SHALL exist and H SHALL follow REQ-013.

Structure
REQ-028 A shared package clk_div_pkg SHALL hold:
- the default RATIO_WD;
- a function computing ceil(A/2);
- a channel-mode enumeration: DISABLED, BYPASS, DIVIDE.
REQ-029 The per-channel logic SHALL be a sub-module clk_div_chan, instantiated N_CH times in a generate loop.

Verification
REQ-030 Even ratio: ch0 enabled with ratio 4 -> o_div_clk repeats 1,1,0,0; o_tick pulses every 4 cycles; the first high occurs 1 cycle after enable.
REQ-031 Odd ratio: ch1 enabled with ratio 5 -> o_div_clk repeats 1,1,1,0,0 (high 3 cycles, low 2).
REQ-032 Mid-period change: ch0 at ratio 4 changes i_div_ratio to 6 at k=1 -> the current period completes as 4, then the next period is 6 cycles (3 high, 3 low).
REQ-033 Bypass: ch2 ratio 1 -> o_div_clk tracks i_ref_clk and o_bypass=1; a change to ratio 2 yields a 1,0 pattern from the next edge.
REQ-034 Reset mid-period: ch0 at ratio 6 with i_rst asserted at k=2 -> all outputs are 0 during reset; after release the channel restarts with 3 cycles high.
REQ-035 Duty option (CLK_DIV_DUTY_EN defined), ratio 8:
- high time 2 -> pattern 1,1,0,0,0,0,0,0;
- high time 9 -> high time clamps to 4.
